// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// -----------------------------------------------------------------------------
// Instruction fetch stage for the RV32I core. It sits directly upstream of the
// combinational instruction ROM. The unit holds the fetch PC and drives the ROM
// byte address. Each returned word is captured, together with its PC, into a
// DEPTH-entry prefetch queue. The queue head is presented to decode over a
// valid/ready handshake. Execute can redirect fetch for taken branches and
// jumps.
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset (4-byte aligned)
//   DEPTH     prefetch queue entries (power of two, >= 2)
//
// Ports:
//   clk             core clock, rising edge
//   reset           synchronous, active-high reset
//   imem_addr       byte address to the instruction ROM (always the fetch PC)
//   imem_data       instruction word from the ROM, same cycle
//   redirect_valid  single-cycle redirect pulse from execute
//   redirect_pc     redirect target byte address
//   inst_valid      queue head holds a valid instruction
//   inst_ready      decode accepts the head this cycle
//   inst_data       queue head instruction word (0 when empty)
//   inst_pc         queue head PC (0 when empty)
//   inst_pc_plus4   inst_pc + 4, link value for JAL/JALR
//   fetch_misalign  only when IF_FETCH_MISALIGN_CHK_EN is defined. This flag is
//                   set by a redirect to a misaligned target, and fetching
//                   stalls until the next aligned redirect.
//
// Optional feature macro: IF_FETCH_MISALIGN_CHK_EN
//   Undefined (default): redirect targets are force-aligned and fetch goes on.
//   Defined: a misaligned redirect raises fetch_misalign and blocks fetch.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
`ifdef IF_FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Fetch PC and queue bookkeeping
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;

  // Queue storage: the contents are only meaningful while count_q says so,
  // so no reset is applied here.
  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] word_mem_q [DEPTH];

  logic push;
  logic pop;
  logic fetch_stall;

`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign fetch_stall    = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign fetch_stall    = 1'b0;
`endif

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);

  // Head fields are zeroed while the queue is empty. This means stale storage
  // never leaks out, and reset shows pc=0 and pc+4=4.
  assign inst_data     = inst_valid ? word_mem_q[rd_ptr_q] : '0;
  assign inst_pc       = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign inst_pc_plus4 = inst_pc + 32'd4;

  assign pop  = inst_valid & inst_ready;
  // A full queue may still accept a push when the head leaves in the same
  // cycle. This keeps throughput at one instruction per cycle.
  assign push = !redirect_valid && !fetch_stall && ((count_q < DEPTH_C) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
`ifdef IF_FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif

    if (redirect_valid) begin
      // Flush: the head popped this cycle (if any) is dropped along with the
      // rest of the queue.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef IF_FETCH_MISALIGN_CHK_EN
      fetch_pc_d = redirect_pc;
      misalign_d = (redirect_pc[1:0] != 2'b00);
`else
      fetch_pc_d = redirect_pc & ~32'h0000_0003;
`endif
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef IF_FETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
`ifdef IF_FETCH_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      word_mem_q[wr_ptr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] exp_q[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
`ifdef IF_FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  // ROM model
  assign imem_data = imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the current head against the next scoreboard entry.
  task automatic consume(input string tag);
    logic [31:0] e;
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
      chk({tag, "_pc"},    inst_pc,       e);
      chk({tag, "_data"},  inst_data,     e ^ 32'hA5A5_0000);
      chk({tag, "_pc4"},   inst_pc_plus4, e + 32'd4);
    end
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_data",  inst_data,     32'h0);
    chk("rst_pc",    inst_pc,       32'h0);
    chk("rst_pc4",   inst_pc_plus4, 32'h4);
    chk("rst_addr",  imem_addr,     32'h0);

    // Streaming with ready held high
    reset = 1'b0;
    inst_ready = 1'b1;
    tick();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    for (int i = 0; i < 4; i++) begin
      consume("stream");
      tick();
    end

    // Backpressure: the queue fills and the fetch PC holds
    reset = 1'b1;
    inst_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_addr",  imem_addr, 32'h8);
    chk("bp_head",  inst_pc,   32'h0);
    inst_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      consume("bp");
      if (i < 2) tick();
    end

    // Redirect with a full queue
    inst_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_00AC;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", {31'b0, inst_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'hAC);
    tick();
    exp_q.push_back(32'hAC);
    exp_q.push_back(32'hB0);
    inst_ready = 1'b1;
    consume("redir");
    tick();
    consume("redir");

    // Wrap of the fetch PC past 2^32
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      consume("wrap");
      tick();
    end

    // Back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    tick();
    exp_q.push_back(32'h400);
    exp_q.push_back(32'h404);
    consume("b2b");
    tick();
    consume("b2b");

    // Reset wins over a simultaneous redirect
    chk("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    reset = 1'b0;
    redirect_valid = 1'b0;
    chk("rr_valid", {31'b0, inst_valid}, 32'd0);
    chk("rr_addr",  imem_addr, 32'h0);
    tick();
    exp_q.push_back(32'h0);
    consume("rr");

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef IF_FETCH_MISALIGN_CHK_EN
    chk("mis_flag", {31'b0, fetch_misalign}, 32'd1);
    tick();
    tick();
    chk("mis_valid", {31'b0, inst_valid}, 32'd0);
    chk("mis_flag_hold", {31'b0, fetch_misalign}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("mis_clear", {31'b0, fetch_misalign}, 32'd0);
    tick();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
`else
    tick();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
`endif
    consume("mis");
    tick();
    consume("mis");

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
